wb_slave_mem: RTL and testbench

Wishbone B4 classic-cycle responder: the slave end of the master/slave interface pair. Its pins are driven from the master side by the existing master-to-slave interconnect, and it answers with ACK/ERR. It backs a small byte-lane-writable memory. Benches use it as the default target behind the interconnect.

---
 rtl/wb_pkg.sv | 11 +
 rtl/wb_slave_ram.sv | 28 ++
 rtl/wb_slave_mem.sv | 127 ++++++++++++
 tb/tb_wb_slave_mem.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone slave definitions: default widths, FSM states and response kinds.
package wb_pkg;
  localparam int ADR_W_DEF = 32;
  localparam int DAT_W_DEF = 32;
  localparam int TGD_W_DEF = 8;
  localparam int TGA_W_DEF = 8;
  localparam int TGC_W_DEF = 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} wb_state_e;
  typedef enum logic {RSP_ACK, RSP_ERR} wb_rsp_e;
endpackage

// File: rtl/wb_slave_ram.sv
// DEPTH x DAT_W storage split into byte lanes; combinational read, async clear.
module wb_slave_ram #(
  parameter int DEPTH = 16,
  parameter int DAT_W = 32,
  localparam int SEL_W = DAT_W / 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] be,
  input  logic [IDX_W-1:0] addr,
  input  logic [DAT_W-1:0] wdata,
  output logic [DAT_W-1:0] rdata
);
  for (genvar b = 0; b < SEL_W; b++) begin : g_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (be[b]) begin
        mem[addr] <= wdata[b*8 +: 8];
      end
    end

    assign rdata[b*8 +: 8] = mem[addr];
  end
endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone B4 classic-cycle memory slave. Define WB_SLV_WAIT_EN to insert
// WAIT_STATES abortable wait cycles before each termination.
module wb_slave_mem
  import wb_pkg::*;
#(
  parameter int ADR_W       = ADR_W_DEF,
  parameter int DAT_W       = DAT_W_DEF,
  parameter int DEPTH       = 16,
  parameter int TGD_W       = TGD_W_DEF,
  parameter int TGA_W       = TGA_W_DEF,
  parameter int TGC_W       = TGC_W_DEF,
  parameter int WAIT_STATES = 0,
  localparam int SEL_W      = DAT_W / 8
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             CYC_I,
  input  logic             STB_I,
  input  logic             WE_I,
  input  logic [ADR_W-1:0] ADR_I,
  input  logic [DAT_W-1:0] DAT_I,
  input  logic [SEL_W-1:0] SEL_I,
  input  logic             LOCK_I,
  input  logic [TGA_W-1:0] TGA_I,
  input  logic [TGC_W-1:0] TGC_I,
  input  logic [TGD_W-1:0] TGD_I,
  output logic [DAT_W-1:0] DAT_O,
  output logic [TGD_W-1:0] TGD_O,
  output logic             ACK_O,
  output logic             ERR_O,
  output logic             RTY_O
);
  localparam int LSB   = $clog2(SEL_W);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int unused_wait = WAIT_STATES;

  typedef struct packed {
    logic             we;
    logic [IDX_W-1:0] idx;
    logic [DAT_W-1:0] dat;
    logic [SEL_W-1:0] sel;
    logic [TGD_W-1:0] tgd;
    wb_rsp_e          rsp;
  } req_t;

  wb_state_e        state, state_nx;
  req_t             live, cap, req;
  logic             req_vld, commit;
  logic [DAT_W-1:0] rd_data, lane_mask;

  wire unused = &{1'b0, LOCK_I, TGA_I, TGC_I, ADR_I[LSB-1:0]};

  assign req_vld = CYC_I & STB_I;

  // Address bits above the word index being nonzero means index >= DEPTH.
  always_comb begin
    live     = '0;
    live.we  = WE_I;
    live.idx = ADR_I[LSB +: IDX_W];
    live.dat = DAT_I;
    live.sel = SEL_I;
    live.tgd = TGD_I;
    live.rsp = ((ADR_I[ADR_W-1:LSB+IDX_W] != '0) || (SEL_I == '0)) ? RSP_ERR : RSP_ACK;
  end

  // Without wait states the write commits on the sampling edge, so use live pins.
  assign req = (state == IDLE) ? live : cap;

`ifdef WB_SLV_WAIT_EN
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) cnt <= '0;
    else       cnt <= (state == WAIT && state_nx == WAIT) ? cnt + 1'b1 : '0;
  end
`endif

  always_comb begin
    state_nx = state;
    case (state)
`ifdef WB_SLV_WAIT_EN
      IDLE: if (req_vld) state_nx = (WAIT_STATES > 0) ? WAIT : RESP;
      WAIT: begin
        if (!req_vld)                              state_nx = IDLE;
        else if (cnt == CNT_W'(WAIT_STATES - 1))   state_nx = RESP;
      end
`else
      IDLE: if (req_vld) state_nx = RESP;
`endif
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state <= IDLE;
      cap   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_vld) cap <= live;
    end
  end

  assign commit = (state_nx == RESP) && req.we && (req.rsp == RSP_ACK);

  wb_slave_ram #(.DEPTH(DEPTH), .DAT_W(DAT_W)) u_ram (
    .clk   (CLK_I),
    .rst   (RST_I),
    .be    ({SEL_W{commit}} & req.sel),
    .addr  (req.idx),
    .wdata (req.dat),
    .rdata (rd_data)
  );

  always_comb begin
    lane_mask = '0;
    for (int b = 0; b < SEL_W; b++) lane_mask[b*8 +: 8] = {8{cap.sel[b]}};
  end

  assign ACK_O = (state == RESP) && (cap.rsp == RSP_ACK);
  assign ERR_O = (state == RESP) && (cap.rsp == RSP_ERR);
  assign RTY_O = 1'b0;
  assign TGD_O = (state == RESP) ? cap.tgd : '0;
  assign DAT_O = (ACK_O && !cap.we) ? (rd_data & lane_mask) : '0;
endmodule

// File: tb/tb_wb_slave_mem.sv
// Directed scoreboard bench for wb_slave_mem; wait-state cases need WB_SLV_WAIT_EN.
module tb_wb_slave_mem;
`ifdef WB_SLV_WAIT_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 0, rst = 1;
  logic        cyc_i = 0, stb_i = 0, we_i = 0, lock_i = 0;
  logic [31:0] adr_i = 0, dat_i = 0;
  logic [3:0]  sel_i = 0;
  logic [7:0]  tga_i = 0, tgc_i = 0, tgd_i = 0;
  logic [31:0] dat_o;
  logic [7:0]  tgd_o;
  logic        ack_o, err_o, rty_o;

  wb_slave_mem #(.WAIT_STATES(3)) dut (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc_i), .STB_I(stb_i), .WE_I(we_i),
    .ADR_I(adr_i), .DAT_I(dat_i), .SEL_I(sel_i), .LOCK_I(lock_i),
    .TGA_I(tga_i), .TGC_I(tgc_i), .TGD_I(tgd_i),
    .DAT_O(dat_o), .TGD_O(tgd_o), .ACK_O(ack_o), .ERR_O(err_o), .RTY_O(rty_o)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    logic        ack, err;
    logic [31:0] dat;
    logic [7:0]  tgd;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [16];
  int          n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request (call at negedge) and push its expected termination.
  task automatic start(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [7:0] tgd);
    exp_t e;
    logic [31:0] idx, mask;
    idx  = adr >> 2;
    mask = '0;
    for (int b = 0; b < 4; b++) if (sel[b]) mask[b*8 +: 8] = 8'hFF;
    e.err = (idx >= 16) || (sel == 0);
    e.ack = !e.err;
    e.tgd = tgd;
    e.dat = '0;
    if (e.ack && we)  model[idx] = (model[idx] & ~mask) | (dat & mask);
    if (e.ack && !we) e.dat = model[idx] & mask;
    sb.push_back(e);
    cyc_i = 1; stb_i = 1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel; tgd_i = tgd;
  endtask

  // Wait (bounded) for a termination, check latency and compare with the scoreboard.
  task automatic wait_term(input int exp_lat, input string tag, output int t_term);
    int n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ack_o || err_o) && n < 20);
    t_term = cyc_cnt;
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_excl"}, {31'b0, ack_o & err_o}, 0);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({tag, "_ack"}, {31'b0, ack_o}, {31'b0, e.ack});
      check({tag, "_err"}, {31'b0, err_o}, {31'b0, e.err});
      check({tag, "_dat"}, dat_o, e.dat);
      check({tag, "_tgd"}, {24'b0, tgd_o}, {24'b0, e.tgd});
    end
  endtask

  task automatic release_bus(input string tag);
    cyc_i = 0; stb_i = 0;
    @(negedge clk);
    check({tag, "_width"}, {30'b0, ack_o, err_o}, 0);
  endtask

  task automatic single(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [7:0] tgd, input string tag);
    int t;
    @(negedge clk);
    start(we, adr, dat, sel, tgd);
    @(posedge clk);
    wait_term(1 + LAT, tag, t);
    release_bus(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ta, tb;
    for (int i = 0; i < 16; i++) model[i] = '0;

    @(negedge clk);
    @(negedge clk);
    check("rst_ack", {31'b0, ack_o}, 0);
    check("rst_err", {31'b0, err_o}, 0);
    check("rst_dat", dat_o, 0);
    check("rst_tgd", {24'b0, tgd_o}, 0);
    check("rst_rty", {31'b0, rty_o}, 0);
    rst = 0;

    // Reset in the middle of a termination cycle
    @(negedge clk);
    start(1, 32'h04, 32'hDEADBEEF, 4'hF, 8'h11);
    @(posedge clk);
    wait_term(1 + LAT, "rstmid", ta);
    #2 rst = 1;
    #1;
    check("rstmid_ack_drop", {31'b0, ack_o}, 0);
    check("rstmid_tgd_drop", {24'b0, tgd_o}, 0);
    cyc_i = 0; stb_i = 0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    @(negedge clk);
    rst = 0;
    single(0, 32'h04, 0, 4'hF, 8'h22, "rd_after_rst");

    // Full word write/read
    single(1, 32'h08, 32'h12345678, 4'hF, 8'h5A, "wr_full");
    single(0, 32'h08, 0, 4'hF, 8'h5B, "rd_full");

    // Byte lanes
    single(1, 32'h0C, 32'hAABBCCDD, 4'hF, 8'h01, "wr_lanes");
    single(1, 32'h0C, 32'h0000EE00, 4'h2, 8'h02, "wr_lane1");
    single(0, 32'h0C, 0, 4'hF, 8'h03, "rd_lanes_all");
    single(0, 32'h0E, 0, 4'h1, 8'h04, "rd_lane0_offs");

    // Errors: out of range and empty select, memory untouched
    single(1, 32'h40, 32'hFFFFFFFF, 4'hF, 8'h41, "err_range_wr");
    single(0, 32'h40, 0, 4'hF, 8'h42, "err_range_rd");
    single(1, 32'h00, 32'hFFFFFFFF, 4'h0, 8'h43, "err_sel0");
    single(0, 32'h00, 0, 4'hF, 8'h44, "rd_after_err");
    single(0, 32'h3C, 0, 4'hF, 8'h45, "rd_last_word");

    // Back-to-back with STB held across both transfers
    @(negedge clk);
    start(1, 32'h00, 32'hCAFEF00D, 4'hF, 8'hB0);
    @(posedge clk);
    wait_term(1 + LAT, "b2b_a", ta);
    start(1, 32'h04, 32'h0BADCAFE, 4'hF, 8'hB1);
    @(posedge clk);
    wait_term(2 + LAT, "b2b_b", tb);
    check("b2b_gap", tb - ta, 2 + LAT);
    release_bus("b2b_b");
    single(0, 32'h00, 0, 4'hF, 8'hB2, "rd_b2b_a");
    single(0, 32'h04, 0, 4'hF, 8'hB3, "rd_b2b_b");

`ifdef WB_SLV_WAIT_EN
    // Abort during the wait: no termination, no write
    @(negedge clk);
    cyc_i = 1; stb_i = 1; we_i = 1; adr_i = 32'h10; dat_i = 32'h11111111; sel_i = 4'hF;
    tgd_i = 8'hA0;
    @(posedge clk);
    @(negedge clk);
    check("abort_early", {30'b0, ack_o, err_o}, 0);
    @(negedge clk);
    stb_i = 0; cyc_i = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_noterm", {30'b0, ack_o, err_o}, 0);
    end
    single(0, 32'h10, 0, 4'hF, 8'hA1, "rd_after_abort");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
